// File: rtl/rgb_pwm_if.sv
// Bundle between the lights selector (master) and the RGB PWM driver (slave).
// RGB_PWM_DIM_EN adds the 2-bit global dimmer; state is a read-only FSM debug view.
interface rgb_pwm_if #(
  parameter int WIDTH = 8
);
  logic [3*WIDTH-1:0] light;
  logic               enable;
`ifdef RGB_PWM_DIM_EN
  logic [1:0]         dim;
`endif
  logic               pwm_r;
  logic               pwm_g;
  logic               pwm_b;
  logic               period_start;
  logic [1:0]         state;

  modport master (
`ifdef RGB_PWM_DIM_EN
    output dim,
`endif
    output light, enable,
    input  pwm_r, pwm_g, pwm_b, period_start, state
  );

  modport slave (
`ifdef RGB_PWM_DIM_EN
    input  dim,
`endif
    input  light, enable,
    output pwm_r, pwm_g, pwm_b, period_start, state
  );
endinterface

// File: rtl/rgb_pwm_driver.sv
// Three-channel PWM LED driver with period-aligned, double-buffered colour loads.
// Optional RGB_PWM_DIM_EN: duty = light >> dim at every latch point.
module rgb_pwm_driver #(
  parameter int PRESCALE = 4,
  parameter int WIDTH    = 8
) (
  input  logic        clk,
  input  logic        rst,
  rgb_pwm_if.slave    bus
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0]    PRE_LAST = PW'(PRESCALE - 1);
  // Last pwm_cnt value is 2^WIDTH-2, so a duty of all-ones stays high all period.
  localparam logic [WIDTH-1:0] CNT_LAST = {{(WIDTH-1){1'b1}}, 1'b0};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [PW-1:0]    pre_q, pre_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] duty_r_q, duty_g_q, duty_b_q;
  logic [WIDTH-1:0] src_r, src_g, src_b;
  logic             tick, wrap, latch;

`ifdef RGB_PWM_DIM_EN
  assign src_r = bus.light[3*WIDTH-1:2*WIDTH] >> bus.dim;
  assign src_g = bus.light[2*WIDTH-1:WIDTH]   >> bus.dim;
  assign src_b = bus.light[WIDTH-1:0]         >> bus.dim;
`else
  assign src_r = bus.light[3*WIDTH-1:2*WIDTH];
  assign src_g = bus.light[2*WIDTH-1:WIDTH];
  assign src_b = bus.light[WIDTH-1:0];
`endif

  assign tick = (pre_q == PRE_LAST);
  assign wrap = tick && (cnt_q == CNT_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      pre_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pre_q   <= pre_d;
      cnt_q   <= cnt_d;
    end
  end

  // Counters default to cleared; only RUN with enable high lets them advance.
  always_comb begin
    state_d = state_q;
    pre_d   = '0;
    cnt_d   = '0;
    latch   = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.enable) state_d = LOAD;
      end
      LOAD: begin
        latch   = 1'b1;
        state_d = bus.enable ? RUN : IDLE;
      end
      RUN: begin
        latch = wrap;
        if (!bus.enable) begin
          state_d = IDLE;
        end else begin
          pre_d = tick ? '0 : pre_q + 1'b1;
          cnt_d = wrap ? '0 : (tick ? cnt_q + 1'b1 : cnt_q);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      duty_r_q <= '0;
      duty_g_q <= '0;
      duty_b_q <= '0;
    end else if (latch) begin
      duty_r_q <= src_r;
      duty_g_q <= src_g;
      duty_b_q <= src_b;
    end
  end

  assign bus.pwm_r        = (state_q == RUN) && (cnt_q < duty_r_q);
  assign bus.pwm_g        = (state_q == RUN) && (cnt_q < duty_g_q);
  assign bus.pwm_b        = (state_q == RUN) && (cnt_q < duty_b_q);
  assign bus.period_start = (state_q == RUN) && (cnt_q == '0) && (pre_q == '0);
  assign bus.state        = state_q;

endmodule

// File: tb/tb_rgb_pwm_driver.sv
// Directed bench for rgb_pwm_driver: one PRESCALE=1 instance and one PRESCALE=4 instance.
module tb_rgb_pwm_driver;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  rgb_pwm_if #(.WIDTH(8)) if1 ();
  rgb_pwm_if #(.WIDTH(8)) if4 ();

  rgb_pwm_driver #(.PRESCALE(1), .WIDTH(8)) dut1 (.clk(clk), .rst(rst), .bus(if1));
  rgb_pwm_driver #(.PRESCALE(4), .WIDTH(8)) dut4 (.clk(clk), .rst(rst), .bus(if4));

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // {period_start, pwm_r, pwm_g, pwm_b} of the selected instance
  function automatic logic [3:0] outs(input bit sel4);
    return sel4 ? {if4.period_start, if4.pwm_r, if4.pwm_g, if4.pwm_b}
                : {if1.period_start, if1.pwm_r, if1.pwm_g, if1.pwm_b};
  endfunction

  // Samples n consecutive cycles (starting now, at a negedge) and checks high counts.
  task automatic count_chk(input string tag, input bit sel4, input int n,
                           input int er, input int eg, input int eb, input int eps);
    int cr = 0, cg = 0, cb = 0, cps = 0;
    logic [3:0] o;
    for (int i = 0; i < n; i++) begin
      o = outs(sel4);
      cps += int'(o[3]);
      cr  += int'(o[2]);
      cg  += int'(o[1]);
      cb  += int'(o[0]);
      @(negedge clk);
    end
    check({tag, "_r"},  cr,  er);
    check({tag, "_g"},  cg,  eg);
    check({tag, "_b"},  cb,  eb);
    check({tag, "_ps"}, cps, eps);
  endtask

  initial begin
    if1.light  = '0;
    if1.enable = 1'b0;
    if4.light  = '0;
    if4.enable = 1'b0;
`ifdef RGB_PWM_DIM_EN
    if1.dim = 2'd0;
    if4.dim = 2'd0;
`endif

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_outs", outs(0), 4'b0000);
    check("rst_state", if1.state, 2'd0);
    rst = 1'b0;
    @(negedge clk);
    check("idle_hold", if1.state, 2'd0);

    // Duty cycles with 24'hFF8000, two-cycle start latency
    if1.light  = 24'hFF8000;
    if1.enable = 1'b1;
    @(negedge clk);
    check("load_state", if1.state, 2'd1);
    check("load_outs", outs(0), 4'b0000);
    @(negedge clk);
    check("run_state", if1.state, 2'd2);
    check("first_run_outs", outs(0), 4'b1110);
    count_chk("duty_ff8000", 0, 255, 255, 128, 0, 1);
    check("period2_start", outs(0), 4'b1110);

    // Mid-period change is deferred to the next wrap
    count_chk("db_part1", 0, 50, 50, 50, 0, 1);
    if1.light = 24'h0000FF;
    count_chk("db_part2", 0, 205, 205, 78, 0, 0);
    count_chk("db_next", 0, 255, 0, 0, 255, 1);

    // Change on the cycle before the wrap edge is captured by that edge
    count_chk("wrap_pre", 0, 254, 0, 0, 254, 1);
    if1.light = 24'h000080;
    count_chk("wrap_last", 0, 1, 0, 0, 1, 0);
    count_chk("wrap_new", 0, 255, 0, 0, 128, 1);

    // Enable drop at pwm_cnt=100
    count_chk("en_pre", 0, 100, 0, 0, 100, 1);
    if1.enable = 1'b0;
    check("en_drop_same", outs(0), 4'b0001);
    @(negedge clk);
    check("en_drop_outs", outs(0), 4'b0000);
    check("en_drop_state", if1.state, 2'd0);
    repeat (3) @(negedge clk);
    check("en_idle_outs", outs(0), 4'b0000);
    if1.light  = 24'h00FF00;
    if1.enable = 1'b1;
    @(negedge clk);
    check("reen_load", outs(0), 4'b0000);
    @(negedge clk);
    check("reen_first", outs(0), 4'b1010);
    count_chk("reen_period", 0, 255, 0, 255, 0, 1);

    // Asynchronous reset mid-period
    if1.light = 24'hFFFFFF;
    count_chk("pre_rst_g", 0, 255, 0, 255, 0, 1);
    count_chk("pre_rst_w", 0, 30, 30, 30, 30, 1);
    #2 rst = 1'b1;
    #1;
    check("async_rst_outs", outs(0), 4'b0000);
    check("async_rst_state", if1.state, 2'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_load", if1.state, 2'd1);
    check("post_rst_load_outs", outs(0), 4'b0000);
    @(negedge clk);
    check("post_rst_run", outs(0), 4'b1111);

    // Prescaler of 4 with light 24'h010101
    if4.light  = 24'h010101;
    if4.enable = 1'b1;
    @(negedge clk);
    check("p4_load", if4.state, 2'd1);
    @(negedge clk);
    check("p4_first", outs(1), 4'b1111);
    count_chk("p4_period", 1, 1020, 4, 4, 4, 1);
    check("p4_next_start", outs(1), 4'b1111);

`ifdef RGB_PWM_DIM_EN
    // Dimmer halves the red duty to 127
    if1.dim    = 2'd1;
    if1.light  = 24'hFF0000;
    if1.enable = 1'b0;
    @(negedge clk);
    if1.enable = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("dim_first", outs(0), 4'b1100);
    count_chk("dim_period", 0, 255, 127, 0, 0, 1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
